// File: rtl/pic_priority_isr_ctrl_if.sv
// CPU-side bus of the PIC interrupt core: INTA handshake, INT, status reads.
// master = CPU/bus side, slave = pic_priority_isr_ctrl.
interface pic_priority_isr_ctrl_if;
  logic       inta_n;
  logic       rd_status;
  logic       rd_isr;
  logic       int_out;
  logic [7:0] data_out;
  logic       data_oe;

  modport master (
    output inta_n, rd_status, rd_isr,
    input  int_out, data_out, data_oe
  );

  modport slave (
    input  inta_n, rd_status, rd_isr,
    output int_out, data_out, data_oe
  );
endinterface

// File: rtl/pic_priority_isr_ctrl.sv
// 8259A interrupt core: IRR, fully-nested priority resolver, ISR, INTA FSM.
// Ports: clk/rst, raw IR lines, IMR/ICW/OCW fields, EOI strobes, bus if, irr/isr.
module pic_priority_isr_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int VEC_HI_BITS = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             ir_in_i,
  input  logic [7:0]             imr_i,
  input  logic                   ltim_i,
  input  logic                   aeoi_i,
  input  logic [VEC_HI_BITS-1:0] vec_base_i,
  input  logic                   init_clr_i,
  input  logic                   eoi_stb_i,
  input  logic                   eoi_specific_i,
  input  logic [2:0]             eoi_level_i,
  pic_priority_isr_ctrl_if.slave bus,
  output logic [7:0]             irr_o,
  output logic [7:0]             isr_o
);

  typedef enum logic [1:0] {
    IDLE,
    ACK1,
    ACK2
  } state_e;

  state_e state_q, state_d;

  logic [7:0]             ir_sq [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] inta_sq;
  logic [7:0]             ir_s;
  logic                   inta_s;

  logic [7:0] ir_prev_q;
  logic       inta_prev_q;
  logic [7:0] irr_q, irr_d;
  logic [7:0] isr_q, isr_d;
  logic       int_q, int_d;
  logic [2:0] lvl_q, lvl_d;
  logic       spur_q, spur_d;
  logic       vec_q, vec_d;

  logic [7:0] req;
  logic [2:0] cand;
  logic       int_ok;
  logic       inta_fall;
  logic       inta_rise;
  logic [7:0] ir_rise;
  logic [7:0] ack_set;
  logic [7:0] aeoi_clr;
  logic [7:0] eoi_clr;
  logic       st_rd;

  function automatic logic [2:0] low_idx(
    input logic [7:0] v
  );
    logic [2:0] r;
    r = 3'd7;
    for (int k = 7; k >= 0; k--) begin
      if (v[k]) r = 3'(k);
    end
    return r;
  endfunction

  // Synchronisers keep running through init_clr.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        ir_sq[k] <= '0;
      end
      inta_sq <= '1;
    end else begin
      ir_sq[0] <= ir_in_i;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        ir_sq[k] <= ir_sq[k-1];
      end
      inta_sq <= {inta_sq[SYNC_STAGES-2:0], bus.inta_n};
    end
  end

  assign ir_s   = ir_sq[SYNC_STAGES-1];
  assign inta_s = inta_sq[SYNC_STAGES-1];

  assign inta_fall = inta_prev_q & ~inta_s;
  assign inta_rise = ~inta_prev_q & inta_s;
  assign ir_rise   = ir_s & ~ir_prev_q;

  assign req  = irr_q & ~imr_i;
  assign cand = low_idx(req);

  // A request is serviceable only if it outranks everything in service.
  assign int_ok = (req != '0) &&
                  ((isr_q == '0) || (cand < low_idx(isr_q)));

  always_ff @(posedge clk) begin
    if (rst || init_clr_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    lvl_d    = lvl_q;
    spur_d   = spur_q;
    vec_d    = vec_q;
    ack_set  = '0;
    aeoi_clr = '0;
    unique case (state_q)
      IDLE: begin
        if (inta_fall) begin
          state_d = ACK1;
          spur_d  = ~int_ok;
          lvl_d   = int_ok ? cand : 3'd7;
          if (int_ok) ack_set = 8'b1 << cand;
        end
      end
      ACK1: begin
        if (inta_rise) state_d = ACK2;
      end
      ACK2: begin
        if (inta_fall) begin
          vec_d = 1'b1;
        end else if (inta_rise) begin
          vec_d   = 1'b0;
          state_d = IDLE;
          if (aeoi_i && !spur_q) aeoi_clr = 8'b1 << lvl_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    eoi_clr = '0;
    if (eoi_stb_i) begin
      // ~x+1 isolates the lowest set bit (highest priority in service).
      eoi_clr = eoi_specific_i ? (8'b1 << eoi_level_i)
                               : (isr_q & (~isr_q + 8'd1));
    end
    // Edge mode: a fresh rising edge beats an acknowledge clear.
    if (ltim_i) begin
      irr_d = ir_s & ~ack_set;
    end else begin
      irr_d = (irr_q & ir_s & ~ack_set) | ir_rise;
    end
    isr_d = (isr_q & ~eoi_clr & ~aeoi_clr) | ack_set;
    int_d = (state_q == IDLE) && !inta_fall && int_ok;
  end

  always_ff @(posedge clk) begin
    if (rst || init_clr_i) begin
      irr_q       <= '0;
      isr_q       <= '0;
      int_q       <= 1'b0;
      lvl_q       <= 3'd0;
      spur_q      <= 1'b0;
      vec_q       <= 1'b0;
      ir_prev_q   <= '0;
      inta_prev_q <= 1'b1;
    end else begin
      irr_q       <= irr_d;
      isr_q       <= isr_d;
      int_q       <= int_d;
      lvl_q       <= lvl_d;
      spur_q      <= spur_d;
      vec_q       <= vec_d;
      ir_prev_q   <= ir_s;
      inta_prev_q <= inta_s;
    end
  end

  assign st_rd = (state_q == IDLE) && bus.rd_status;

  always_comb begin
    bus.data_out = '0;
    if (vec_q) begin
      bus.data_out = {vec_base_i, lvl_q};
    end else if (st_rd) begin
      bus.data_out = bus.rd_isr ? isr_q : irr_q;
    end
  end

  assign bus.data_oe = vec_q | st_rd;
  assign bus.int_out = int_q;
  assign irr_o       = irr_q;
  assign isr_o       = isr_q;

endmodule

// File: doc/pic_priority_isr_ctrl.md
Name: pic_priority_isr_ctrl

Overview:
- Interrupt core of the 8259A PIC. Contains the Interrupt Request Register (IRR), the fully-nested priority resolver and the In-Service Register (ISR), plus the CPU INTA handshake state machine.
- Sits downstream of the interrupt mask register and the read/write logic, which supply the IMR and ICW/OCW fields.
- Drives INT to the CPU and places the interrupt vector and the IRR/ISR status onto the internal data bus.

Parameters:
- SYNC_STAGES, 2, number of flip-flop stages synchronising ir_in and inta_n to clk (minimum 2).
- VEC_HI_BITS, 5, number of ICW2 upper bits used as the vector base. Fixed at 5 for 8086 mode.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- ir_in  in  8  raw IR0..IR7 request lines; IR0 has the highest priority.
- imr  in  8  mask register; bit=1 masks that IR.
- ltim  in  1  ICW1 bit 3; 1 = level-triggered, 0 = edge-triggered.
- aeoi  in  1  ICW4 bit 1; 1 = automatic EOI.
- vec_base  in  5  ICW2[7:3].
- init_clr  in  1  one-cycle pulse on an ICW1 write.
- eoi_stb  in  1  one-cycle pulse on an OCW2 EOI command.
- eoi_specific  in  1  1 = specific EOI, 0 = non-specific EOI.
- eoi_level  in  3  IR level targeted by a specific EOI.
- rd_status  in  1  status read strobe.
- rd_isr  in  1  OCW3 RIS; 1 = read ISR, 0 = read IRR.
- inta_n  in  1  CPU interrupt acknowledge, active-low.
- int_out  out  1  interrupt request to the CPU.
- data_out  out  8  value driven onto the internal data bus.
- data_oe  out  1  data_out valid, drive enable for the bus.
- irr  out  8  current IRR.
- isr  out  8  current ISR.

Behaviour:
- Reset and init_clr: irr, isr, int_out, data_out, data_oe all 0; FSM to IDLE; edge-detect history set to 0. init_clr has identical effect except that SYNC_STAGES registers keep running.
- Synchronisation:
  - ir_in and inta_n pass through SYNC_STAGES flip-flops before any use.
  - inta falling and rising edges are detected on the synchronised signal.
- IRR in edge mode (ltim=0): bit i is set when the synchronised ir[i] goes 0->1. It holds until acknowledged, or until it is cleared because ir[i] dropped before acknowledge.
- IRR in level mode (ltim=1): irr[i] = synchronised ir[i], except that the bit is cleared in the cycle it is acknowledged.
- Priority resolution:
  - req = irr & ~imr.
  - cand = lowest-index set bit of req.
  - int_out = 1 in IDLE when req≠0 and cand is numerically lower than the lowest set bit of isr (or isr=0).
  - int_out is registered; latency is 1 clk from irr/imr/isr change.
- FSM states: IDLE, ACK1, ACK2.
  - IDLE -> ACK1 on inta falling edge:
    - Latch lvl=cand.
    - If req≠0 and the interrupt is valid: set isr[lvl], clear irr[lvl].
    - Otherwise it is spurious: lvl=7, ISR/IRR unchanged.
    - int_out -> 0.
  - ACK1 -> ACK2 on inta rising edge. No bus drive during the first pulse (data_oe=0).
  - ACK2:
    - On inta falling edge: data_out={vec_base,lvl}, data_oe=1 while inta_n is low.
    - On inta rising edge: data_oe=0; if aeoi=1 and the interrupt was not spurious, clear isr[lvl]; go to IDLE.
- EOI (eoi_stb):
  - Non-specific: clear the lowest-index set bit of isr; no-op if isr=0.
  - Specific: clear isr[eoi_level].
- Simultaneous events:
  - EOI in the same cycle as the ACK1 ISR set: both apply; EOI is evaluated against the pre-update ISR.
  - Edge set and acknowledge-clear on the same IRR bit in one cycle: set wins.
- Status reads: when rd_status=1 in IDLE, data_out = rd_isr ? isr : irr and data_oe=1 for that cycle. The FSM vector drive has priority over status reads.
- rst or init_clr during ACK1/ACK2 aborts the cycle and returns to IDLE with the reset values.

Test Plan:
- Edge mode, imr=0, vec_base=5'b01000, pulse IR3 -> int_out=1 within SYNC_STAGES+2 clk; two INTA pulses -> data_out=0x43 during the second pulse, isr=0x08, irr=0.
- IR5 in service (isr=0x20), then raise IR2 -> int_out=1; raise IR6 instead -> int_out stays 0.
- imr=0x04, raise IR2 -> int_out=0; clear imr -> int_out=1 one clk later.
- aeoi=1, IR1 acknowledge -> isr returns to 0 after the second INTA rising edge. aeoi=0 with isr=0x0A and a non-specific EOI -> isr=0x08; then specific EOI level 3 -> isr=0.
- Spurious: IR4 raised then dropped (level mode) before the first INTA -> vector {vec_base,3'b111}, isr unchanged.
- rst asserted during ACK2 -> next clk data_oe=0, int_out=0, isr=0, FSM IDLE.
